sram_read_aligner: RTL and testbench
====================================

# sram_read_aligner

Read-response side of the SRAM memory controller. It accepts one read request at a time (address and size) and waits a fixed SRAM read latency. It then selects the addressed chip's data bus, shifts the addressed byte lanes down to bit 0, extends the result, and returns it on a valid/ready response channel. It sits between the SRAM data outputs and the bus-side slave, alongside the byte-enable/chip-enable decoder.

## Interface
Parameters:
- N_SRAM, 2: number of SRAM chips.
- SRAM_DEPTH, 1024: words per chip.
- SRAM_WIDTH, 4: bytes per word. Each chip spans SRAM_DEPTH*SRAM_WIDTH bytes.
- READ_LATENCY, 2: cycles from request acceptance until sram_rdata is valid. Legal range is 1 or more.

Ports:
- CLK  in  1  clock. Everything is on the rising edge.
- nRST  in  1  reset. Synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid and req_ready are both high.
- req_addr  in  32  byte address.
- req_size  in  2  transfer size: 0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_sign  in  1  sign-extend the result. This port exists only with SRAM_RD_SIGN_EXT_EN.
- sram_rdata  in  32*N_SRAM  concatenated chip read buses. Chip k is [32k+31:32k].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high.
- rsp_data  out  32  aligned, extended read data.
- rsp_err  out  1  request was misaligned, illegal-size or out of range.

## Operation
- The FSM has three states: IDLE, WAIT and RESP.
  - IDLE: req_ready=1. On accept, latch addr[1:0], size, chip index, error flag and sign. Load the counter with READ_LATENCY-1 and go to WAIT.
  - WAIT: decrement the counter each cycle. When the counter is 0, capture the aligned data of the latched chip into rsp_data and go to RESP.
  - RESP: rsp_valid=1 and rsp_data/rsp_err are held stable. On rsp_ready, return to IDLE, or go directly to WAIT if a new request is accepted in the same cycle.
- req_ready = (state==IDLE) || (state==RESP && rsp_ready). Back-to-back requests therefore see no bubble.
- Chip index = req_addr / (SRAM_DEPTH*SRAM_WIDTH).
- rsp_err is set if any of the following holds:
  - chip index is N_SRAM or more;
  - size is 3;
  - size is half and addr[0]=1;
  - size is word and addr[1:0] is not 0.
- On error, rsp_data=0. The latency is unchanged.
- Alignment: shifted = rdata >> (8*addr[1:0]).
  - byte: keep bits [7:0].
  - half: keep bits [15:0].
  - word: pass through unchanged.
- Upper bits are zero-filled unless sign extension is enabled and active (see Configuration).
- Only one transaction is outstanding at a time. While in WAIT, req_valid is ignored.

## Timing
- Reset values: state=IDLE, rsp_valid=0, rsp_data=0, rsp_err=0, counter=0, latched fields=0.
- req_ready is 1 in the first cycle after nRST is released.
- Latency, for a request accepted in cycle c:
  - sram_rdata is sampled at the end of cycle c+READ_LATENCY.
  - rsp_valid is first high in cycle c+READ_LATENCY+1.
- Throughput is one response per READ_LATENCY+1 cycles when rsp_ready is held high.
- Backpressure: rsp_valid stays high and rsp_data/rsp_err stay unchanged until rsp_ready. req_ready stays 0 during that time.
- Reset mid-transaction (nRST low in WAIT or RESP): the transaction is abandoned and no response is issued. The reset values apply on the next edge.
- rsp_valid never depends combinationally on rsp_ready.

## Configuration
- SRAM_RD_SIGN_EXT_EN defined:
  - the req_sign port is present and latched with the request;
  - byte and half results are sign-extended from bit 7 or bit 15 when req_sign=1, and zero-extended otherwise.
- SRAM_RD_SIGN_EXT_EN undefined:
  - there is no req_sign port;
  - byte and half results are always zero-extended.

## Structure
- Shared package sram_ctrl_pkg contains:
  - size_t enum: SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=2;
  - state enum: IDLE, WAIT, RESP;
  - constant DATA_W=32.
- Sub-module sram_rdata_align is purely combinational: 32-bit word, addr[1:0], size and sign in; aligned and extended word out. It is instantiated once, ahead of the rsp_data register.

## Test plan
All scenarios use N_SRAM=2, SRAM_DEPTH=1024, SRAM_WIDTH=4 and READ_LATENCY=2, so chip 1 starts at byte address 0x1000.
- Word read, addr 0x0000_0004, chip0 = 0xDEADBEEF, accepted in cycle c -> rsp_valid in cycle c+3, rsp_data=0xDEADBEEF, rsp_err=0.
- Byte read, addr 0x0000_1003, chip1 = 0x8A123456 -> rsp_data=0x0000008A. With the macro and req_sign=1 -> 0xFFFFFF8A.
- Half read, addr 0x0000_0002, chip0 = 0x12345678 -> 0x00001234. Half read at addr 0x0000_0001 -> rsp_err=1, rsp_data=0.
- Word read at addr 0x0000_2000 (out of range) -> rsp_err=1, rsp_data=0, rsp_valid in cycle c+3.
- Backpressure:
  - hold rsp_ready=0 for 5 cycles -> rsp_data stable and req_ready=0 throughout;
  - then assert rsp_ready together with req_valid -> the new request is accepted in that cycle and its response arrives 3 cycles later.
- Drop nRST for one cycle during WAIT -> no rsp_valid follows, and req_ready=1 on the first cycle after release.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM controller read path.
package sram_ctrl_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/sram_rdata_align.sv
// Combinational byte-lane aligner: shifts the addressed lanes to bit 0, then zero/sign-extends.
// No latency, no flow control.
module sram_rdata_align
  import sram_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] i_word,
  input  logic [1:0]        i_addr_lo,
  input  logic [1:0]        i_size,
  input  logic              i_sign,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] w_shifted;

  assign w_shifted = i_word >> {i_addr_lo, 3'b000};

  always_comb begin
    o_data = w_shifted;
    case (i_size)
      SIZE_BYTE: o_data = {{(DATA_W-8){i_sign & w_shifted[7]}}, w_shifted[7:0]};
      SIZE_HALF: o_data = {{(DATA_W-16){i_sign & w_shifted[15]}}, w_shifted[15:0]};
      default:   o_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/sram_read_aligner.sv
// SRAM read-response path: one request outstanding, response READ_LATENCY+1 cycles after accept,
// held under rsp_ready backpressure. SRAM_RD_SIGN_EXT_EN adds the req_sign port.
module sram_read_aligner
  import sram_ctrl_pkg::*;
#(
  parameter int N_SRAM       = 2,
  parameter int SRAM_DEPTH   = 1024,
  parameter int SRAM_WIDTH   = 4,
  parameter int READ_LATENCY = 2
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  input  logic [1:0]               req_size,
`ifdef SRAM_RD_SIGN_EXT_EN
  input  logic                     req_sign,
`endif
  input  logic [DATA_W*N_SRAM-1:0] sram_rdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     rsp_err
);

  localparam int CHIP_BYTES = SRAM_DEPTH * SRAM_WIDTH;
  localparam int CHIP_W     = (N_SRAM > 1) ? $clog2(N_SRAM) : 1;
  localparam int CNT_W      = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [1:0]          r_addr_lo, r_size;
  logic [CHIP_W-1:0]   r_chip;
  logic                r_err, r_sign;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_rsp_err;

  logic                w_accept, w_capture, w_sign_in, w_req_err;
  logic [31:0]         w_chip_idx;
  logic [DATA_W-1:0]   w_chip_rdata, w_aligned;

`ifdef SRAM_RD_SIGN_EXT_EN
  assign w_sign_in = req_sign;
`else
  assign w_sign_in = 1'b0;
`endif

  assign w_chip_idx = req_addr / 32'(CHIP_BYTES);
  assign w_req_err  = (w_chip_idx >= 32'(N_SRAM))
                   || (req_size == 2'd3)
                   || ((req_size == SIZE_HALF) && req_addr[0])
                   || ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));

  always_comb begin
    req_ready   = 1'b0;
    w_capture   = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = WAIT;
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        // Response handshake frees the slot, so a new request can chain straight into WAIT.
        if (rsp_ready) begin
          req_ready   = 1'b1;
          w_state_nxt = req_valid ? WAIT : IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_accept  = req_valid && req_ready;
  assign rsp_valid = (r_state == RESP);
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;

  // Explicit compare mux: a truncated out-of-range index must never select a nonexistent lane.
  always_comb begin
    w_chip_rdata = '0;
    for (int k = 0; k < N_SRAM; k++) begin
      if (r_chip == CHIP_W'(k)) w_chip_rdata = sram_rdata[k*DATA_W +: DATA_W];
    end
  end

  sram_rdata_align u_align (
    .i_word    (w_chip_rdata),
    .i_addr_lo (r_addr_lo),
    .i_size    (r_size),
    .i_sign    (r_sign),
    .o_data    (w_aligned)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_cnt      <= '0;
      r_addr_lo  <= '0;
      r_size     <= '0;
      r_chip     <= '0;
      r_err      <= 1'b0;
      r_sign     <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr_lo <= req_addr[1:0];
        r_size    <= req_size;
        r_chip    <= w_chip_idx[CHIP_W-1:0];
        r_err     <= w_req_err;
        r_sign    <= w_sign_in;
        r_cnt     <= CNT_W'(READ_LATENCY - 1);
      end else if ((r_state == WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_capture) begin
        r_rsp_data <= r_err ? '0 : w_aligned;
        r_rsp_err  <= r_err;
      end
    end
  end

endmodule

// File: tb/tb_sram_read_aligner.sv
// Scoreboard bench for sram_read_aligner: expected responses queued at accept, checked at handshake.
module tb_sram_read_aligner;

`ifdef SRAM_RD_SIGN_EXT_EN
  localparam bit SE = 1'b1;
`else
  localparam bit SE = 1'b0;
`endif

  logic        CLK, nRST;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
`ifdef SRAM_RD_SIGN_EXT_EN
  logic        req_sign;
`endif
  logic [63:0] sram_rdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_rsp = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  bit          fresh = 0;
  bit          stall_prev = 0;
  logic [31:0] hold_data = '0;
  logic        hold_err = 1'b0;
  logic [31:0] exp_data;
  logic        exp_err;
  logic [32:0] sb_q[$];

  sram_read_aligner dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_size   (req_size),
`ifdef SRAM_RD_SIGN_EXT_EN
    .req_sign   (req_sign),
`endif
    .sram_rdata (sram_rdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial forever begin
    @(posedge CLK);
    cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Monitor: protocol checks, then pop on response handshake, then push on request accept.
  initial forever begin
    logic [32:0] e;
    @(negedge CLK);
    if (!nRST) begin
      sb_q.delete();
      fresh      = 0;
      stall_prev = 0;
    end else begin
      if (sb_q.size() == 0) chk("idle_vld", 32'(rsp_valid), 0);
      if (stall_prev) begin
        chk("hold_vld", 32'(rsp_valid), 1);
        chk("hold_dat", rsp_data, hold_data);
        chk("hold_err", 32'(rsp_err), 32'(hold_err));
      end
      if (rsp_valid && fresh) begin
        chk("latency", 32'(cyc - acc_cyc), 3);
        fresh = 0;
      end
      if (rsp_valid && !rsp_ready) begin
        chk("stall_rdy", 32'(req_ready), 0);
        stall_prev = 1;
        hold_data  = rsp_data;
        hold_err   = rsp_err;
      end else begin
        stall_prev = 0;
      end
      if (rsp_valid && rsp_ready && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("rsp_dat", rsp_data, e[31:0]);
        chk("rsp_err", 32'(e[32] ? rsp_err : rsp_err), 32'(e[32]));
        n_rsp++;
      end
      if (req_valid && req_ready) begin
        sb_q.push_back({exp_err, exp_data});
        acc_cyc = cyc;
        fresh   = 1;
      end
    end
  end

  task automatic set_req(input logic [31:0] addr, input logic [1:0] size, input logic sgn,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] edata, input logic eerr);
    req_addr   = addr;
    req_size   = size;
`ifdef SRAM_RD_SIGN_EXT_EN
    req_sign   = sgn;
`else
    if (sgn) req_size = size;
`endif
    sram_rdata = {d1, d0};
    exp_data   = edata;
    exp_err    = eerr;
    req_valid  = 1'b1;
  endtask

  task automatic drive_req(input logic [31:0] addr, input logic [1:0] size, input logic sgn,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] edata, input logic eerr);
    int n = 0;
    @(posedge CLK); #1;
    set_req(addr, size, sgn, d0, d1, edata, eerr);
    do begin
      @(negedge CLK);
      n++;
    end while (!req_ready && n < 20);
    if (!req_ready) chk("req_timeout", 32'(req_ready), 1);
    @(posedge CLK); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge CLK); #1;
      n++;
    end while ((sb_q.size() != 0 || rsp_valid) && n < 40);
    if (n >= 40) chk("rsp_timeout", 32'(sb_q.size()), 0);
  endtask

  initial begin
    int n;
    int acc;
    nRST = 1'b0; req_valid = 1'b0; req_addr = '0; req_size = '0;
`ifdef SRAM_RD_SIGN_EXT_EN
    req_sign = 1'b0;
`endif
    sram_rdata = '0; rsp_ready = 1'b1; exp_data = '0; exp_err = 1'b0;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_vld", 32'(rsp_valid), 0);
    chk("rst_dat", rsp_data, 0);
    chk("rst_err", 32'(rsp_err), 0);
    chk("rst_rdy", 32'(req_ready), 1);
    @(posedge CLK); #1 nRST = 1'b1;
    @(negedge CLK);
    chk("rdy_post_rst", 32'(req_ready), 1);

    // Functional vectors: {addr, size, sign, chip0, chip1, expected data, expected err}
    drive_req(32'h0000_0004, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'h5555_5555, 32'hDEAD_BEEF, 1'b0); wait_idle();
    drive_req(32'h0000_1003, 2'd0, 1'b1, 32'h1111_1111, 32'h8A12_3456,
              SE ? 32'hFFFF_FF8A : 32'h0000_008A, 1'b0); wait_idle();
    drive_req(32'h0000_0002, 2'd1, 1'b0, 32'h1234_5678, 32'hAAAA_AAAA, 32'h0000_1234, 1'b0); wait_idle();
    drive_req(32'h0000_0001, 2'd1, 1'b0, 32'h1234_5678, 32'hAAAA_AAAA, 32'h0000_0000, 1'b1); wait_idle();
    drive_req(32'h0000_2000, 2'd2, 1'b0, 32'h1234_5678, 32'h9999_9999, 32'h0000_0000, 1'b1); wait_idle();
    drive_req(32'h0000_0000, 2'd3, 1'b0, 32'h1234_5678, 32'h9999_9999, 32'h0000_0000, 1'b1); wait_idle();
    drive_req(32'h0000_1002, 2'd2, 1'b0, 32'h1234_5678, 32'h9999_9999, 32'h0000_0000, 1'b1); wait_idle();
    drive_req(32'h0000_0001, 2'd0, 1'b0, 32'h0000_C300, 32'hFFFF_FFFF, 32'h0000_00C3, 1'b0); wait_idle();
    drive_req(32'h0000_0000, 2'd0, 1'b1, 32'h0000_00F0, 32'h0000_0000,
              SE ? 32'hFFFF_FFF0 : 32'h0000_00F0, 1'b0); wait_idle();
    drive_req(32'h0000_1FFF, 2'd0, 1'b1, 32'hFFFF_FFFF, 32'h7F00_0000, 32'h0000_007F, 1'b0); wait_idle();
    drive_req(32'h0000_1002, 2'd1, 1'b1, 32'h0000_0000, 32'hFEDC_0000,
              SE ? 32'hFFFF_FEDC : 32'h0000_FEDC, 1'b0); wait_idle();

    // Throughput: continuous requests with rsp_ready high -> one accept every 3 cycles.
    @(posedge CLK); #1;
    set_req(32'h0000_1000, 2'd2, 1'b0, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0);
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (req_ready) acc++;
    end
    @(posedge CLK); #1 req_valid = 1'b0;
    chk("thru_acc", 32'(acc), 4);
    wait_idle();

    // Backpressure: 5 stalled RESP cycles, then release together with a new request.
    @(posedge CLK); #1 rsp_ready = 1'b0;
    drive_req(32'h0000_0008, 2'd2, 1'b0, 32'h0BAD_F00D, 32'h0, 32'h0BAD_F00D, 1'b0);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!rsp_valid && n < 20);
    chk("bp_vld", 32'(rsp_valid), 1);
    repeat (4) @(posedge CLK);
    #1 set_req(32'h0000_0006, 2'd1, 1'b0, 32'hBEEF_0000, 32'h0, 32'h0000_BEEF, 1'b0);
    @(posedge CLK); #1 rsp_ready = 1'b1;
    @(negedge CLK);
    chk("bp_b2b_rdy", 32'(req_ready), 1);
    @(posedge CLK); #1 req_valid = 1'b0;
    wait_idle();

    // Reset while in WAIT: transaction abandoned, no response.
    drive_req(32'h0000_0004, 2'd2, 1'b0, 32'h1357_9BDF, 32'h0, 32'h1357_9BDF, 1'b0);
    nRST = 1'b0;
    @(posedge CLK); #1 nRST = 1'b1;
    @(negedge CLK);
    chk("rdy_mid_rst", 32'(req_ready), 1);
    repeat (8) @(negedge CLK);
    chk("rsp_cnt", 32'(n_rsp), 32'(11 + 4 + 2));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
